// File: rtl/priv_1_12_trap_sequencer.sv
// priv_1_12_trap_sequencer
// Sequences machine-mode trap entry (exception / interrupt) and trap return
// (mret). It arbitrates incoming requests, waits for the pipeline to drain,
// commits the CSR updates in a single cycle, then redirects fetch.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   exc_valid/exc_code/exc_tval/epc       exception request and its data
//   int_pending/int_code                  interrupt request and its cause
//   mret                                  trap-return request
//   pipe_clear                            pipeline drained
//   curr_*                                current privilege / CSR state
//   busy                                  sequencer not idle (front-end stalls)
//   inject_*                              one-cycle CSR write strobes
//   next_*                                CSR write data (valid with strobes)
//   insert_pc / priv_pc                   one-cycle fetch redirect and target
//   dbg_state                             current FSM state (debug)
//
// Request handshake: exc_valid, int_pending and mret are level requests. A
// request counts as accepted only in a cycle where the sequencer is IDLE
// (busy=0) at the rising edge. While busy=1 every request is ignored and the
// requester has to hold or re-present it after busy drops.
module priv_1_12_trap_sequencer #(
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_tval,
  input  logic [31:0] epc,
  input  logic        int_pending,
  input  logic [3:0]  int_code,
  input  logic        mret,
  input  logic        pipe_clear,
  input  logic [1:0]  curr_priv,
  input  logic        curr_mstatus_mie,
  input  logic        curr_mstatus_mpie,
  input  logic [1:0]  curr_mstatus_mpp,
  input  logic [31:0] curr_mtvec,
  input  logic [31:0] curr_mepc,
  output logic        busy,
  output logic        inject_mcause,
  output logic        inject_mepc,
  output logic        inject_mtval,
  output logic        inject_mstatus,
  output logic        inject_priv,
  output logic [31:0] next_mcause,
  output logic [31:0] next_mepc,
  output logic [31:0] next_mtval,
  output logic        next_mstatus_mie,
  output logic        next_mstatus_mpie,
  output logic [1:0]  next_mstatus_mpp,
  output logic [1:0]  next_priv,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_CLEAR = 2'd1,
    ST_COMMIT     = 2'd2,
    ST_REDIRECT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KIND_EXC = 2'd0,
    KIND_INT = 2'd1,
    KIND_RET = 2'd2
  } kind_e;

  // RESET_PRIV is informational only: after reset the core is in M-mode, and
  // the sequencer never writes privilege while idle, so no logic depends on it.
  if (RESET_PRIV == 2'b10) begin : g_reserved_reset_priv
  end

  state_e      state_q, state_d;
  kind_e       kind_q;
  logic [3:0]  code_q;
  logic [31:2] epc_q;   // mepc is always written 4-byte aligned
  logic [31:0] tval_q;
  logic [1:0]  priv_q;
  logic        mie_q;
  logic        mpie_q;
  logic [1:0]  mpp_q;

  logic int_take;
  logic accept;

  // In M-mode an interrupt is only taken with mstatus.MIE set; lower modes
  // always take enabled interrupts.
  assign int_take = int_pending && ((curr_priv != 2'b11) || curr_mstatus_mie);
  assign accept   = (state_q == ST_IDLE) && (exc_valid || int_take || mret);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (accept) state_d = ST_WAIT_CLEAR;
      ST_WAIT_CLEAR: if (pipe_clear) state_d = ST_COMMIT;
      ST_COMMIT:     state_d = ST_REDIRECT;
      ST_REDIRECT:   state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_EXC;
      code_q  <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      priv_q  <= '0;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
      mpp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        epc_q  <= epc[31:2];
        priv_q <= curr_priv;
        mie_q  <= curr_mstatus_mie;
        mpie_q <= curr_mstatus_mpie;
        mpp_q  <= curr_mstatus_mpp;
        if (exc_valid) begin
          kind_q <= KIND_EXC;
          code_q <= exc_code;
          tval_q <= exc_tval;
        end else if (int_take) begin
          kind_q <= KIND_INT;
          code_q <= int_code;
          tval_q <= '0;
        end else begin
          kind_q <= KIND_RET;
          code_q <= '0;
          tval_q <= '0;
        end
      end
    end
  end

  logic [31:0] vec_base;
  assign vec_base = {curr_mtvec[31:2], 2'b00};

  always_comb begin
    busy              = (state_q != ST_IDLE);
    inject_mcause     = 1'b0;
    inject_mepc       = 1'b0;
    inject_mtval      = 1'b0;
    inject_mstatus    = 1'b0;
    inject_priv       = 1'b0;
    next_mcause       = '0;
    next_mepc         = '0;
    next_mtval        = '0;
    next_mstatus_mie  = 1'b0;
    next_mstatus_mpie = 1'b0;
    next_mstatus_mpp  = '0;
    next_priv         = '0;
    insert_pc         = 1'b0;
    priv_pc           = '0;
    case (state_q)
      ST_COMMIT: begin
        if (kind_q == KIND_RET) begin
          inject_mstatus    = 1'b1;
          inject_priv       = 1'b1;
          next_priv         = mpp_q;
          next_mstatus_mie  = mpie_q;
          next_mstatus_mpie = 1'b1;
          next_mstatus_mpp  = 2'b00;
        end else begin
          inject_mcause     = 1'b1;
          inject_mepc       = 1'b1;
          inject_mtval      = 1'b1;
          inject_mstatus    = 1'b1;
          inject_priv       = 1'b1;
          next_mcause       = {(kind_q == KIND_INT), 27'b0, code_q};
          next_mepc         = {epc_q, 2'b00};
          next_mtval        = tval_q;
          next_mstatus_mpie = mie_q;
          next_mstatus_mie  = 1'b0;
          next_mstatus_mpp  = priv_q;
          next_priv         = 2'b11;
        end
      end
      ST_REDIRECT: begin
        insert_pc = 1'b1;
        if (kind_q == KIND_RET) begin
          priv_pc = curr_mepc;
        end else if ((curr_mtvec[1:0] == 2'b01) && (kind_q == KIND_INT)) begin
          // Vectored mode; mode 2'b1x is reserved and falls back to direct.
          priv_pc = vec_base + {26'b0, code_q, 2'b00};
        end else begin
          priv_pc = vec_base;
        end
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
module tb_priv_1_12_trap_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_tval;
  logic [31:0] epc;
  logic        int_pending;
  logic [3:0]  int_code;
  logic        mret;
  logic        pipe_clear;
  logic [1:0]  curr_priv;
  logic        curr_mstatus_mie;
  logic        curr_mstatus_mpie;
  logic [1:0]  curr_mstatus_mpp;
  logic [31:0] curr_mtvec;
  logic [31:0] curr_mepc;
  logic        busy;
  logic        inject_mcause, inject_mepc, inject_mtval, inject_mstatus, inject_priv;
  logic [31:0] next_mcause, next_mepc, next_mtval;
  logic        next_mstatus_mie, next_mstatus_mpie;
  logic [1:0]  next_mstatus_mpp, next_priv;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 CLK = ~CLK;

  priv_1_12_trap_sequencer #(.RESET_PRIV(2'b11)) dut (
    .CLK(CLK), .RST(RST),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval), .epc(epc),
    .int_pending(int_pending), .int_code(int_code), .mret(mret),
    .pipe_clear(pipe_clear), .curr_priv(curr_priv),
    .curr_mstatus_mie(curr_mstatus_mie), .curr_mstatus_mpie(curr_mstatus_mpie),
    .curr_mstatus_mpp(curr_mstatus_mpp), .curr_mtvec(curr_mtvec), .curr_mepc(curr_mepc),
    .busy(busy), .inject_mcause(inject_mcause), .inject_mepc(inject_mepc),
    .inject_mtval(inject_mtval), .inject_mstatus(inject_mstatus), .inject_priv(inject_priv),
    .next_mcause(next_mcause), .next_mepc(next_mepc), .next_mtval(next_mtval),
    .next_mstatus_mie(next_mstatus_mie), .next_mstatus_mpie(next_mstatus_mpie),
    .next_mstatus_mpp(next_mstatus_mpp), .next_priv(next_priv),
    .insert_pc(insert_pc), .priv_pc(priv_pc), .dbg_state(dbg_state)
  );

  // {inject_mcause, inject_mepc, inject_mtval, inject_mstatus, inject_priv, insert_pc}
  logic [5:0] strobes;
  assign strobes = {inject_mcause, inject_mepc, inject_mtval, inject_mstatus,
                    inject_priv, insert_pc};
  // {mie, mpie, mpp, priv}
  logic [5:0] mstat;
  assign mstat = {next_mstatus_mie, next_mstatus_mpie, next_mstatus_mpp, next_priv};
  logic [31:0] data_or;
  assign data_or = next_mcause | next_mepc | next_mtval | priv_pc;

  // driver tasks: advance one clock, inputs change / outputs sampled 1ns after edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic exp_busy);
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, exp_busy});
    chk({tag, "_strobes"}, {26'b0, strobes}, 32'h0);
    chk({tag, "_mstat"}, {26'b0, mstat}, 32'h0);
    chk({tag, "_data"}, data_or, 32'h0);
  endtask

  initial begin
    RST = 1'b1; exc_valid = 0; exc_code = 0; exc_tval = 0; epc = 0;
    int_pending = 0; int_code = 0; mret = 0; pipe_clear = 1;
    curr_priv = 2'b11; curr_mstatus_mie = 0; curr_mstatus_mpie = 0;
    curr_mstatus_mpp = 0; curr_mtvec = 0; curr_mepc = 0;
    step(); step();
    RST = 1'b0;
    chk_quiet("reset", 1'b0);
    chk("reset_state", {30'b0, dbg_state}, 32'd0);

    // ---- exception from U-mode, direct mtvec
    exc_valid = 1; exc_code = 4'd2; epc = 32'h8000_0104; exc_tval = 32'h0000_0013;
    curr_priv = 2'b00; curr_mstatus_mie = 1; curr_mstatus_mpie = 0; curr_mstatus_mpp = 2'b00;
    curr_mtvec = 32'h8000_0000; pipe_clear = 1;
    step();
    exc_valid = 0;
    chk_quiet("exc_wait", 1'b1);
    chk("exc_wait_state", {30'b0, dbg_state}, 32'd1);
    step();
    chk("exc_commit_strobes", {26'b0, strobes}, 32'b111110);
    chk("exc_mcause", next_mcause, 32'h0000_0002);
    chk("exc_mepc", next_mepc, 32'h8000_0104);
    chk("exc_mtval", next_mtval, 32'h0000_0013);
    chk("exc_mstat", {26'b0, mstat}, {26'b0, 1'b0, 1'b1, 2'b00, 2'b11});
    chk("exc_commit_pc", priv_pc, 32'h0);
    step();
    chk("exc_redir_strobes", {26'b0, strobes}, 32'b000001);
    chk("exc_priv_pc", priv_pc, 32'h8000_0000);
    chk("exc_redir_mcause", next_mcause, 32'h0);
    step();
    chk_quiet("exc_idle", 1'b0);

    // ---- vectored interrupt from M-mode, unaligned epc, tval forced to 0
    int_pending = 1; int_code = 4'd7; curr_mtvec = 32'h8000_0001; curr_priv = 2'b11;
    curr_mstatus_mie = 1; epc = 32'h8000_0203; exc_tval = 32'hDEAD_BEEF;
    step();
    int_pending = 0;
    chk_quiet("int_wait", 1'b1);
    step();
    chk("int_commit_strobes", {26'b0, strobes}, 32'b111110);
    chk("int_mcause", next_mcause, 32'h8000_0007);
    chk("int_mepc", next_mepc, 32'h8000_0200);
    chk("int_mtval", next_mtval, 32'h0);
    chk("int_mstat", {26'b0, mstat}, {26'b0, 1'b0, 1'b1, 2'b11, 2'b11});
    step();
    chk("int_redir_strobes", {26'b0, strobes}, 32'b000001);
    chk("int_priv_pc", priv_pc, 32'h8000_001C);
    step();

    // ---- reserved mtvec mode 2'b11 behaves as direct
    int_pending = 1; int_code = 4'd3; curr_mtvec = 32'h8000_0103;
    step();
    int_pending = 0;
    step();
    chk("mode3_mcause", next_mcause, 32'h8000_0003);
    step();
    chk("mode3_priv_pc", priv_pc, 32'h8000_0100);
    step();

    // ---- masked interrupt in M-mode with mie=0
    int_pending = 1; int_code = 4'd11; curr_priv = 2'b11; curr_mstatus_mie = 0;
    step();
    chk_quiet("masked_1", 1'b0);
    step();
    chk_quiet("masked_2", 1'b0);

    // ---- priority: exception beats interrupt and mret; vectored mtvec ignored
    curr_mstatus_mie = 1; exc_valid = 1; exc_code = 4'd5; mret = 1;
    curr_mtvec = 32'h8000_0001; epc = 32'h0000_0400; exc_tval = 32'h0000_1234;
    step();
    exc_valid = 0; int_pending = 0; mret = 0;
    chk("prio_busy", {31'b0, busy}, 32'd1);
    step();
    chk("prio_mcause", next_mcause, 32'h0000_0005);
    chk("prio_mtval", next_mtval, 32'h0000_1234);
    step();
    chk("prio_priv_pc", priv_pc, 32'h8000_0000);
    step();

    // ---- mret
    mret = 1; curr_priv = 2'b11; curr_mstatus_mie = 0; curr_mstatus_mpie = 1;
    curr_mstatus_mpp = 2'b00; curr_mepc = 32'h0000_2000;
    step();
    mret = 0;
    chk_quiet("ret_wait", 1'b1);
    step();
    chk("ret_strobes", {26'b0, strobes}, 32'b000110);
    chk("ret_mstat", {26'b0, mstat}, {26'b0, 1'b1, 1'b1, 2'b00, 2'b00});
    chk("ret_mcause", next_mcause, 32'h0);
    step();
    chk("ret_redir_strobes", {26'b0, strobes}, 32'b000001);
    chk("ret_priv_pc", priv_pc, 32'h0000_2000);
    step();
    chk_quiet("ret_idle", 1'b0);

    // ---- pipe_clear held low for 5 extra cycles; requests during wait ignored
    pipe_clear = 0; exc_valid = 1; exc_code = 4'd3; epc = 32'h0000_0100;
    exc_tval = 32'h0000_0044; curr_priv = 2'b00; curr_mtvec = 32'h8000_0000;
    step();
    exc_code = 4'd9; exc_tval = 32'h0000_0099; int_pending = 1; mret = 1;
    for (int i = 0; i < 5; i++) begin
      chk_quiet("hold", 1'b1);
      step();
    end
    chk_quiet("hold_last", 1'b1);
    exc_valid = 0; int_pending = 0; mret = 0; pipe_clear = 1;
    step();
    chk("hold_mcause", next_mcause, 32'h0000_0003);
    chk("hold_mtval", next_mtval, 32'h0000_0044);
    step();
    chk("hold_redir_strobes", {26'b0, strobes}, 32'b000001);
    step();
    chk_quiet("hold_idle", 1'b0);

    // ---- reset during WAIT_CLEAR
    pipe_clear = 0; exc_valid = 1; exc_code = 4'd1;
    step();
    exc_valid = 0;
    chk("rstw_state", {30'b0, dbg_state}, 32'd1);
    RST = 1;
    step();
    RST = 0; pipe_clear = 1;
    chk_quiet("rstw_after", 1'b0);
    step();
    chk_quiet("rstw_after2", 1'b0);
    step();
    chk_quiet("rstw_after3", 1'b0);

    // ---- reset during COMMIT
    exc_valid = 1; exc_code = 4'd4;
    step();
    exc_valid = 0;
    step();
    chk("rstc_commit", {31'b0, inject_mcause}, 32'd1);
    RST = 1;
    step();
    RST = 0;
    chk_quiet("rstc_after", 1'b0);
    step();
    chk_quiet("rstc_after2", 1'b0);

    // ---- reset wins over a simultaneous request
    RST = 1; exc_valid = 1;
    step();
    RST = 0; exc_valid = 0;
    chk_quiet("rst_wins", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
